branch_predict_ctrl: RTL and testbench
======================================

// Module: branch_predict_ctrl
// PURPOSE
//   Branch history table (BHT) plus init sequencer supplying the branch unit's taken/not-taken prediction.
//   Decode looks up by PC each cycle; execute writes back the resolved outcome. Direct-mapped 2-bit
//   saturating counters replace the branch unit's single-bit prediction register. On reset an FSM walks
//   and clears the table before predictions are valid. Also counts mispredicts for perf debug.
// PARAMETERS
//   ENTRIES   64   number of BHT entries; power of two, >= 2
//   IDX_W     $clog2(ENTRIES)   index width (derived, not overridden)
//   CNT_W     32   mispredict counter width
// PORTS
//   Clock             in   1       core clock, all state on rising edge
//   Reset             in   1       synchronous, active-high reset
//   lookup_pc         in   32      PC of instruction in decode
//   predict_taken     out  1       1 = predict branch taken for lookup_pc
//   bht_ready         out  1       1 = table initialised, predict_taken meaningful
//   update_valid      in   1       execute resolved a CONDITIONAL_TYPE branch this cycle
//   update_pc         in   32      PC of the resolved branch (PCDEC in execute)
//   update_taken      in   1       actual outcome (branchConfirmed)
//   update_mispredict in   1       execute flushed due to wrong prediction
//   mispredict_count  out  CNT_W   saturating count of mispredicts since reset
// BEHAVIOUR
//   Reset: state=BP_INIT, init_idx=0, bht_ready=0, predict_taken=0, mispredict_count=0.
//   Index: idx = pc[IDX_W+1:2] for both ports; pc[1:0] ignored; higher bits alias (no tags).
//   FSM BP_INIT: each cycle writes WNT (2'b01) to entry init_idx, init_idx++;
//     when init_idx==ENTRIES-1 is written -> BP_RUN next cycle. Exactly ENTRIES cycles of bht_ready=0.
//     In BP_INIT: predict_taken=0, update_valid ignored (no counter or stat change).
//   FSM BP_RUN: bht_ready=1; terminal state until Reset.
//   Lookup: combinational, zero latency: predict_taken = bht_ready & bht[idx(lookup_pc)][1].
//   Update (BP_RUN, update_valid=1): entry idx(update_pc) written at next rising edge:
//     taken: SNT->WNT->WT->ST, ST holds; not taken: ST->WT->WNT->SNT, SNT holds.
//   Same-cycle lookup and update to same index: lookup returns pre-update value (read-before-write);
//     new value visible from the following cycle. No bypass.
//   mispredict_count: +1 when BP_RUN & update_valid & update_mispredict; holds at all-ones.
//   update_mispredict without update_valid: ignored.
//   Reset asserted mid-operation (either state): returns to BP_INIT next edge, table re-initialised,
//     count cleared; any same-cycle update is discarded.
//   Outputs have no X after first Reset edge; table contents before first init are don't-care
//     since bht_ready gates predict_taken.
// STRUCTURE
//   core_types_pkg: typedef enum logic {BP_INIT, BP_RUN} bp_state_t;
//     typedef logic [1:0] bht_cnt_t; constants BHT_SNT=2'b00, BHT_WNT=2'b01, BHT_WT=2'b10, BHT_ST=2'b11.
//   coreUtils: function bht_cnt_t bht_next(bht_cnt_t c, logic taken) - saturating step.
//   Sub-module bht_array: ENTRIES x 2-bit flop array, one async read port, one sync write port
//     (we, waddr, wdata); controller muxes init writes vs update writes onto the single write port.
// TESTING
//   1. Reset 1 cycle, release -> bht_ready=0 for 64 cycles, then 1; lookup every idx -> predict_taken=0.
//   2. update pc=0x100 taken twice -> entry 0x00 goes 01->10->11; lookup 0x100 in first update cycle=0,
//      next cycle=1.
//   3. Saturation: 3 more taken updates keep 11; one not-taken -> 10 (predict 1); second -> 01 (predict 0);
//      two more -> 00 holds.
//   4. Aliasing: taken updates at pc=0x200 -> lookup pc=0x300 (0x200+4*64) predicts 1, pc=0x204 predicts 0.
//   5. update_valid=1, update_mispredict=1 during BP_INIT -> no table change, count stays 0;
//      3 mispredicts in BP_RUN -> count=3; with CNT_W=4, 20 mispredicts -> count=15.
//   6. Reset pulsed in BP_RUN with entry at 11 and count=5 -> bht_ready=0 for 64 cycles,
//      then entry predicts 0 and count=0.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared branch-predictor types, counter encodings and the saturating counter step.
package core_types_pkg;

    typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_SNT = 2'b00;
    localparam bht_cnt_t BHT_WNT = 2'b01;
    localparam bht_cnt_t BHT_WT  = 2'b10;
    localparam bht_cnt_t BHT_ST  = 2'b11;

    // 2-bit saturating step toward the resolved outcome
    function automatic bht_cnt_t bht_next(input bht_cnt_t c, input logic taken);
        if (taken)
            return (c == BHT_ST) ? BHT_ST : bht_cnt_t'(c + 2'b01);
        else
            return (c == BHT_SNT) ? BHT_SNT : bht_cnt_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht_array.sv
// BHT storage: ENTRIES x 2-bit flops, async lookup/update reads, one sync write port.
module bht_array
    import core_types_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  bht_cnt_t         wdata,
    input  logic [IDX_W-1:0] raddr,
    output bht_cnt_t         rdata,
    input  logic [IDX_W-1:0] raddr_upd,
    output bht_cnt_t         rdata_upd
);

    // No reset: contents are rewritten by the init walk before bht_ready rises
    bht_cnt_t mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata     = mem[raddr];
    assign rdata_upd = mem[raddr_upd];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch history table controller: init sequencer, PC-indexed lookup/update and mispredict counter.
module branch_predict_ctrl
    import core_types_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      lookup_pc,
    output logic             predict_taken,
    output logic             bht_ready,
    input  logic             update_valid,
    input  logic [31:0]      update_pc,
    input  logic             update_taken,
    input  logic             update_mispredict,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    bp_state_t        state;
    logic [IDX_W-1:0] init_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    bht_cnt_t         lookup_cnt;
    bht_cnt_t         update_cnt;
    logic             we;
    logic [IDX_W-1:0] waddr;
    bht_cnt_t         wdata;
    logic             unused_pc_bits;

    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign update_idx = update_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                              update_pc[31:IDX_W+2], update_pc[1:0]};

    bht_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (Clock),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (lookup_idx),
        .rdata     (lookup_cnt),
        .raddr_upd (update_idx),
        .rdata_upd (update_cnt)
    );

    // Init walk owns the write port; resolved updates only land once running
    always_comb begin
        we    = 1'b0;
        waddr = update_idx;
        wdata = bht_next(update_cnt, update_taken);
        if (!Reset) begin
            if (state == BP_INIT) begin
                we    = 1'b1;
                waddr = init_idx;
                wdata = BHT_WNT;
            end else if (update_valid) begin
                we = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state            <= BP_INIT;
            init_idx         <= '0;
            mispredict_count <= '0;
        end else begin
            case (state)
                BP_INIT: begin
                    init_idx <= init_idx + IDX_W'(1);
                    if (init_idx == IDX_W'(ENTRIES - 1))
                        state <= BP_RUN;
                end
                BP_RUN: begin
                    if (update_valid && update_mispredict && (mispredict_count != '1))
                        mispredict_count <= mispredict_count + CNT_W'(1);
                end
                default: state <= BP_INIT;
            endcase
        end
    end

    assign bht_ready     = (state == BP_RUN);
    assign predict_taken = bht_ready & lookup_cnt[1];

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl (64 entries, 32-bit and 4-bit counters).
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lookup_pc = '0;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic        update_mispredict = 1'b0;
    logic        predict_taken, bht_ready;
    logic        predict_taken4, bht_ready4;
    logic [31:0] mcount;
    logic [3:0]  mcount4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl #(.ENTRIES(64), .CNT_W(32)) dut (
        .Clock(clk), .Reset(rst), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken), .bht_ready(bht_ready),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_mispredict(update_mispredict),
        .mispredict_count(mcount)
    );

    branch_predict_ctrl #(.ENTRIES(64), .CNT_W(4)) dut4 (
        .Clock(clk), .Reset(rst), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken4), .bht_ready(bht_ready4),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_mispredict(update_mispredict),
        .mispredict_count(mcount4)
    );

    // Called at negedge+1 right after reset release; counts samples with bht_ready low
    task automatic wait_ready(output int n);
        n = 0;
        while (!bht_ready && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    // Called at a negedge; drives one update cycle, returns at the next negedge
    task automatic do_update(input logic [31:0] pc, input logic taken, input logic mis);
        update_pc         = pc;
        update_taken      = taken;
        update_mispredict = mis;
        update_valid      = 1'b1;
        @(negedge clk);
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        update_valid      = 1'b1;
        update_mispredict = 1'b1;
        update_taken      = 1'b1;
        update_pc         = 32'h100;
        lookup_pc         = 32'h100;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bht_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bht_ready); end
        n_checks++;
        if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL reset_predict got=%b exp=0", predict_taken); end
        n_checks++;
        if (mcount !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", mcount); end
        wait_ready(n);
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        n_checks++;
        if (n !== 64) begin n_fail++; $display("FAIL init_cycles got=%0d exp=64", n); end
        n_checks++;
        if (bht_ready4 !== 1'b1) begin n_fail++; $display("FAIL init_ready4 got=%b exp=1", bht_ready4); end
        n_checks++;
        if (mcount !== 32'd0) begin n_fail++; $display("FAIL init_ignore_count got=%0d exp=0", mcount); end
        n_checks++;
        if (mcount4 !== 4'd0) begin n_fail++; $display("FAIL init_ignore_count4 got=%0d exp=0", mcount4); end
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 32'h1000 + 32'(i) * 4;
            #1;
            n_checks++;
            if (predict_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL init_lookup idx=%0d got=%b exp=0", i, predict_taken);
            end
        end
    endtask

    task automatic test_update_rbw;
        @(negedge clk);
        lookup_pc    = 32'h100;
        update_pc    = 32'h100;
        update_taken = 1'b1;
        update_valid = 1'b1;
        #1;
        n_checks++;
        if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL rbw_first got=%b exp=0", predict_taken); end
        @(negedge clk);
        #1;
        n_checks++;
        if (predict_taken !== 1'b1) begin n_fail++; $display("FAIL rbw_second got=%b exp=1", predict_taken); end
        @(negedge clk);
        update_valid = 1'b0;
        #1;
        n_checks++;
        if (predict_taken !== 1'b1) begin n_fail++; $display("FAIL update_st got=%b exp=1", predict_taken); end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        lookup_pc = 32'h100;
        for (int i = 0; i < 3; i++) do_update(32'h100, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b1) begin n_fail++; $display("FAIL sat_st_hold got=%b exp=1", predict_taken); end
        @(negedge clk);
        do_update(32'h100, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b1) begin n_fail++; $display("FAIL sat_wt got=%b exp=1", predict_taken); end
        @(negedge clk);
        do_update(32'h100, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL sat_wnt got=%b exp=0", predict_taken); end
        @(negedge clk);
        do_update(32'h100, 1'b0, 1'b0);
        do_update(32'h100, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL sat_snt got=%b exp=0", predict_taken); end
        // From SNT a single taken reaches only WNT
        @(negedge clk);
        do_update(32'h100, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL sat_snt_hold got=%b exp=0", predict_taken); end
    endtask

    task automatic test_aliasing;
        @(negedge clk);
        do_update(32'h200, 1'b1, 1'b0);
        do_update(32'h200, 1'b1, 1'b0);
        lookup_pc = 32'h300;
        #1;
        n_checks++;
        if (predict_taken !== 1'b1) begin n_fail++; $display("FAIL alias_300 got=%b exp=1", predict_taken); end
        lookup_pc = 32'h202;
        #1;
        n_checks++;
        if (predict_taken !== 1'b1) begin n_fail++; $display("FAIL alias_lowbits got=%b exp=1", predict_taken); end
        lookup_pc = 32'h204;
        #1;
        n_checks++;
        if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL alias_204 got=%b exp=0", predict_taken); end
    endtask

    task automatic test_mispredict;
        @(negedge clk);
        for (int i = 0; i < 3; i++) do_update(32'h40, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (mcount !== 32'd3) begin n_fail++; $display("FAIL mis_three got=%0d exp=3", mcount); end
        n_checks++;
        if (mcount4 !== 4'd3) begin n_fail++; $display("FAIL mis_three4 got=%0d exp=3", mcount4); end
        @(negedge clk);
        update_mispredict = 1'b1;
        repeat (3) @(negedge clk);
        update_mispredict = 1'b0;
        #1;
        n_checks++;
        if (mcount !== 32'd3) begin n_fail++; $display("FAIL mis_no_valid got=%0d exp=3", mcount); end
        @(negedge clk);
        for (int i = 0; i < 17; i++) do_update(32'h40, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (mcount !== 32'd20) begin n_fail++; $display("FAIL mis_twenty got=%0d exp=20", mcount); end
        n_checks++;
        if (mcount4 !== 4'd15) begin n_fail++; $display("FAIL mis_sat4 got=%0d exp=15", mcount4); end
    endtask

    task automatic test_reset_midrun;
        int n;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        wait_ready(n);
        do_update(32'h100, 1'b1, 1'b1);
        do_update(32'h100, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) do_update(32'h40, 1'b0, 1'b1);
        lookup_pc = 32'h100;
        #1;
        n_checks++;
        if (mcount !== 32'd5) begin n_fail++; $display("FAIL mid_pre_count got=%0d exp=5", mcount); end
        n_checks++;
        if (predict_taken !== 1'b1) begin n_fail++; $display("FAIL mid_pre_predict got=%b exp=1", predict_taken); end
        @(negedge clk);
        rst               = 1'b1;
        update_pc         = 32'h104;
        update_taken      = 1'b1;
        update_mispredict = 1'b1;
        update_valid      = 1'b1;
        @(negedge clk);
        rst               = 1'b0;
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        #1;
        n_checks++;
        if (mcount !== 32'd0) begin n_fail++; $display("FAIL mid_reset_count got=%0d exp=0", mcount); end
        wait_ready(n);
        n_checks++;
        if (n !== 64) begin n_fail++; $display("FAIL mid_init_cycles got=%0d exp=64", n); end
        n_checks++;
        if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL mid_post_predict got=%b exp=0", predict_taken); end
        lookup_pc = 32'h104;
        #1;
        n_checks++;
        if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL mid_discard_update got=%b exp=0", predict_taken); end
        n_checks++;
        if (mcount !== 32'd0) begin n_fail++; $display("FAIL mid_post_count got=%0d exp=0", mcount); end
        n_checks++;
        if (mcount4 !== 4'd0) begin n_fail++; $display("FAIL mid_post_count4 got=%0d exp=0", mcount4); end
    endtask

    initial begin
        test_reset;
        test_update_rbw;
        test_saturation;
        test_aliasing;
        test_mispredict;
        test_reset_midrun;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
